// File: rtl/melody_player_if.sv
// Control, melody-ROM and buzzer-side signals of the melody player, bundled as one port.
interface melody_player_if #(
  parameter int SW = 1
);
  logic          start;
  logic          stop;
  logic          pause;
  logic          loop_en;
  logic [SW-1:0] song_sel;
  logic [1:0]    oct_up;
  logic [SW+7:0] rom_addr;
  logic [31:0]   rom_tone;
  logic [7:0]    beat_num;
  logic [31:0]   tone;
  logic          playing;
  logic          beat_stb;
  logic          done;

  modport master (
    output start, stop, pause, loop_en, song_sel, oct_up, rom_tone,
    input  rom_addr, beat_num, tone, playing, beat_stb, done
  );

  modport slave (
    input  start, stop, pause, loop_en, song_sel, oct_up, rom_tone,
    output rom_addr, beat_num, tone, playing, beat_stb, done
  );
endinterface

// File: rtl/melody_player.sv
// Steps an external tone table one beat per TICKS cycles; tone is registered one cycle after rom_addr.
// No backpressure: stop > start > pause > beat advance, and pause (level) freezes the tick counter.
module melody_player #(
  parameter int CLK_HZ  = 100000000,
  parameter int BEAT_HZ = 8,
  parameter int LEN     = 60,
  parameter int SONGS   = 2,
  parameter int SILENCE = 20000
) (
  input logic             clk,
  input logic             rst_n,
  melody_player_if.slave  bus
);
  localparam int TICKS = CLK_HZ / BEAT_HZ;
  localparam int SW    = (SONGS > 1) ? $clog2(SONGS) : 1;
  localparam int TW    = $clog2(TICKS);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    beat_q, beat_d;
  logic [SW-1:0] song_q, song_d;
  logic [31:0]   tone_q, tone_d;
  logic          stb;
  logic          done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      beat_q  <= '0;
      song_q  <= '0;
      tone_q  <= 32'(SILENCE);
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      beat_q  <= beat_d;
      song_q  <= song_d;
      tone_q  <= tone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    beat_d  = beat_q;
    song_d  = song_q;
    stb     = 1'b0;
    done_c  = 1'b0;
    if (bus.stop && state_q != IDLE) begin
      state_d = IDLE;
      tick_d  = '0;
      beat_d  = '0;
    end else if (bus.start) begin
      // Out-of-range song indices fall back to song 0
      state_d = PLAY;
      tick_d  = '0;
      beat_d  = '0;
      song_d  = (32'(bus.song_sel) < 32'(SONGS)) ? bus.song_sel : '0;
    end else if (state_q == PLAY && bus.pause) begin
      state_d = PAUSE;
    end else if (state_q == PAUSE && !bus.pause) begin
      state_d = PLAY;
    end else if (state_q == PLAY) begin
      if (tick_q == TW'(TICKS - 1)) begin
        stb    = 1'b1;
        tick_d = '0;
        if (beat_q == 8'(LEN - 1)) begin
          beat_d = '0;
          if (!bus.loop_en) begin
            state_d = IDLE;
            done_c  = 1'b1;
          end
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_comb begin
    tone_d = 32'(SILENCE);
    if (state_q == PLAY && bus.rom_tone != 32'(SILENCE))
      tone_d = bus.rom_tone << bus.oct_up;
  end

  assign bus.rom_addr = {song_q, beat_q};
  assign bus.beat_num = beat_q;
  assign bus.tone     = tone_q;
  assign bus.playing  = (state_q == PLAY) || (state_q == PAUSE);
  assign bus.beat_stb = stb;
  assign bus.done     = done_c;
endmodule
